// File: rtl/fetch_pkg.sv
`default_nettype none
//============================================================================
// Module   : fetch_pkg
// Brief    : Shared types, BTB/queue entry layouts and 2-bit counter helpers.
// Revision : 1.0
//============================================================================
package fetch_pkg;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  ctr_t;

    localparam ctr_t STRONG_NT = 2'b00;
    localparam ctr_t WEAK_NT   = 2'b01;
    localparam ctr_t WEAK_T    = 2'b10;
    localparam ctr_t STRONG_T  = 2'b11;

    // Tag is kept right-justified in a full word so any BTB size fits.
    typedef struct packed {
        logic  valid;
        word_t tag;
        word_t target;
        ctr_t  ctr;
    } btb_entry_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  pred_taken;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == STRONG_T) ? c : c + 2'd1;
        end
        return (c == STRONG_NT) ? c : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
//============================================================================
// Module   : fetch_queue
// Brief    : Circular FIFO with flush; head is presented combinationally.
// Revision : 1.0
//============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//============================================================================
// Module   : fetch_unit
// Brief    : PC register, direct-mapped BTB predictor and instruction queue.
// Revision : 1.0
//============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC    = 32'h00000000,
    parameter int    BTB_ENTRIES = 16,
    parameter int    IQ_DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        freeze,
    input  logic        misprediction,
    input  logic [31:0] correct_pc,
    input  logic        update_btb,
    input  logic [31:0] update_pc,
    input  logic [31:0] branch_target,
    input  logic        branch_outcome,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        pred_taken
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    word_t      pc_q, pc_d;
    btb_entry_t btb_q [BTB_ENTRIES];
    btb_entry_t btb_d [BTB_ENTRIES];
    btb_entry_t upd_entry;

    logic [IDX-1:0] w_lk_idx;
    logic [IDX-1:0] w_up_idx;
    word_t          w_lk_tag;
    word_t          w_up_tag;
    logic           w_hit;
    word_t          w_pred_next;
    logic           w_push;
    logic           w_pop;
    logic           w_q_empty;
    logic           w_q_full;
    iq_entry_t      w_push_entry;
    iq_entry_t      w_head;

    // Lookup reads the registered array, so a same-cycle update is not seen.
    assign w_lk_idx    = pc_q[IDX+1:2];
    assign w_lk_tag    = pc_q >> (IDX + 2);
    assign w_up_idx    = update_pc[IDX+1:2];
    assign w_up_tag    = update_pc >> (IDX + 2);
    assign w_hit       = btb_q[w_lk_idx].valid && (btb_q[w_lk_idx].tag == w_lk_tag)
                         && btb_q[w_lk_idx].ctr[1];
    assign w_pred_next = w_hit ? btb_q[w_lk_idx].target : pc_q + 32'd4;

    assign imemaddr    = pc_q;
    assign imemREN     = !w_q_full && !freeze && !misprediction;
    assign w_push      = imemREN && ihit;
    assign instr_valid = !w_q_empty && !freeze;
    assign w_pop       = instr_valid && instr_ready;

    assign w_push_entry = '{instr: imemload, pc: pc_q, pred_taken: w_hit};
    assign instr        = w_head.instr;
    assign pc           = w_head.pc;
    assign pred_taken   = w_head.pred_taken;

    always_comb begin
        pc_d = pc_q;
        if (misprediction) begin
            pc_d = correct_pc;
        end else if (w_push) begin
            pc_d = w_pred_next;
        end
    end

    always_comb begin
        btb_d     = btb_q;
        upd_entry = btb_q[w_up_idx];
        if (update_btb) begin
            if (upd_entry.valid && (upd_entry.tag == w_up_tag)) begin
                upd_entry.ctr = ctr_next(upd_entry.ctr, branch_outcome);
                if (branch_outcome) begin
                    upd_entry.target = branch_target;
                end
            end else begin
                upd_entry = '{valid:  1'b1,
                              tag:    w_up_tag,
                              target: branch_target,
                              ctr:    branch_outcome ? WEAK_T : WEAK_NT};
            end
            btb_d[w_up_idx] = upd_entry;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            btb_q <= btb_d;
        end
    end

    fetch_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (IQ_ENTRY_W)
    ) u_queue (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (misprediction),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .empty     (w_q_empty),
        .full      (w_q_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit with a behavioural fetch model.
// Revision : 1.0
//============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam int          BTB_N    = 16;
    localparam int          IQ_D     = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        freeze = 1'b0;
    logic        misprediction = 1'b0;
    logic [31:0] correct_pc = '0;
    logic        update_btb = 1'b0;
    logic [31:0] update_pc = '0;
    logic [31:0] branch_target = '0;
    logic        branch_outcome = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred_taken;

    fetch_unit #(
        .RESET_PC    (RESET_PC),
        .BTB_ENTRIES (BTB_N),
        .IQ_DEPTH    (IQ_D)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .imemload       (imemload),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .freeze         (freeze),
        .misprediction  (misprediction),
        .correct_pc     (correct_pc),
        .update_btb     (update_btb),
        .update_pc      (update_pc),
        .branch_target  (branch_target),
        .branch_outcome (branch_outcome),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .pred_taken     (pred_taken)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    bit          m_v   [BTB_N];
    logic [31:0] m_tag [BTB_N];
    logic [31:0] m_tgt [BTB_N];
    int          m_ctr [BTB_N];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_index(input logic [31:0] a);
        return int'((a / 4) % BTB_N);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a / (4 * BTB_N);
    endfunction

    task automatic model_reset();
        sb.delete();
        m_pc = RESET_PC;
        for (int i = 0; i < BTB_N; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
    endtask

    // Monitor: whenever a head is presented it must match the oldest expected entry.
    always @(negedge CLK) begin
        #2;
        if (!RST && instr_valid) begin
            if (sb.size() == 0) begin
                chk("head_unexpected", 32'd1, 32'd0);
            end else begin
                chk("head_instr", instr, sb[0].instr);
                chk("head_pc", pc, sb[0].pc);
                chk("head_pred", {31'd0, pred_taken}, {31'd0, sb[0].pt});
                if (instr_ready && !freeze && !misprediction) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic ih, input logic [31:0] ld, input logic rdy,
                       input logic fr, input logic mis, input logic [31:0] cpc,
                       input logic upd, input logic [31:0] upc, input logic [31:0] tgt,
                       input logic outc);
        bit ren;
        bit hit;
        int ix;
        @(negedge CLK);
        ihit = ih; imemload = ld; instr_ready = rdy; freeze = fr;
        misprediction = mis; correct_pc = cpc; update_btb = upd;
        update_pc = upc; branch_target = tgt; branch_outcome = outc;
        #1;
        ren = (sb.size() < IQ_D) && !fr && !mis;
        chk("imemREN", {31'd0, imemREN}, {31'd0, ren});
        chk("imemaddr", imemaddr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (sb.size() > 0) && !fr});
        #2;
        ix  = m_index(m_pc);
        hit = m_v[ix] && (m_tag[ix] == m_tagof(m_pc)) && (m_ctr[ix] >= 2);
        if (mis) begin
            sb.delete();
            m_pc = cpc;
        end else if (ren && ih) begin
            sb.push_back('{instr: ld, pc: m_pc, pt: hit});
            m_pc = hit ? m_tgt[ix] : m_pc + 32'd4;
        end
        if (upd) begin
            ix = m_index(upc);
            if (m_v[ix] && m_tag[ix] == m_tagof(upc)) begin
                m_ctr[ix] = outc ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                 : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
                if (outc) m_tgt[ix] = tgt;
            end else begin
                m_v[ix] = 1; m_tag[ix] = m_tagof(upc); m_tgt[ix] = tgt;
                m_ctr[ix] = outc ? 2 : 1;
            end
        end
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, '0, rdy, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Reset is raised between clock edges to show it acts without a clock.
    task automatic do_reset();
        @(negedge CLK);
        #3;
        RST = 1'b1;
        ihit = 1'b1; freeze = 1'b0; misprediction = 1'b0; update_btb = 1'b0;
        #1;
        chk("rst_imemaddr", imemaddr, RESET_PC);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        ihit = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) return 32'hFFFFFFFC;
        a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h0;
        return a | (32'($urandom_range(0, 63)) << 2);
    endfunction

    initial begin
        model_reset();
        do_reset();

        // Straight-line fetch with a consumer always ready.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h80, 1'b1, 0, 0, '0, 0, '0, '0, 0);
        idle(1'b1);
        chk("seq_pc_reg", imemaddr, 32'h10);

        // Fill to capacity, then a single pop.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h1000 + i, 1'b0, 0, 0, '0, 0, '0, '0, 0);
        chk("full_ren", {31'd0, imemREN}, 32'd0);
        chk("full_pc_held", imemaddr, 32'h10);
        cyc(1'b1, 32'h2000, 1'b1, 0, 0, '0, 0, '0, '0, 0);
        chk("pop_full_ren", {31'd0, imemREN}, 32'd0);
        cyc(1'b1, 32'h2001, 1'b0, 0, 0, '0, 0, '0, '0, 0);
        chk("after_pop_ren", {31'd0, imemREN}, 32'd1);

        // Taken allocation redirects the next fetch.
        do_reset();
        cyc(1'b0, '0, 1'b0, 0, 0, '0, 1'b1, 32'h80000000, 32'h80000100, 1'b1);
        cyc(1'b0, '0, 1'b0, 0, 1'b1, 32'h80000000, 0, '0, '0, 0);
        cyc(1'b1, 32'hB0, 1'b0, 0, 0, '0, 0, '0, '0, 0);
        idle(1'b0);
        chk("btb_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("btb_next_addr", imemaddr, 32'h80000100);

        // Two not-taken updates drop the counter below the predict threshold.
        cyc(1'b0, '0, 1'b0, 0, 0, '0, 1'b1, 32'h80000000, 32'h0, 1'b0);
        cyc(1'b0, '0, 1'b0, 0, 0, '0, 1'b1, 32'h80000000, 32'h0, 1'b0);
        cyc(1'b0, '0, 1'b0, 0, 1'b1, 32'h80000000, 0, '0, '0, 0);
        cyc(1'b1, 32'hB1, 1'b0, 0, 0, '0, 0, '0, '0, 0);
        idle(1'b0);
        chk("btb_nt_addr", imemaddr, 32'h80000004);
        chk("btb_nt_pred", {31'd0, pred_taken}, 32'd0);

        // Misprediction flush with a fetch landing in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + i, 1'b0, 0, 0, '0, 0, '0, '0, 0);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 0, 1'b1, 32'h200, 0, '0, '0, 0);
        idle(1'b0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        chk("mis_addr", imemaddr, 32'h200);

        // Freeze holds everything; the same head comes back afterwards.
        for (int i = 0; i < 2; i++) cyc(1'b1, 32'h400 + i, 1'b0, 0, 0, '0, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h500, 1'b1, 1'b1, 0, '0, 0, '0, '0, 0);
            chk("frz_valid", {31'd0, instr_valid}, 32'd0);
            chk("frz_addr", imemaddr, 32'h208);
        end
        idle(1'b0);
        chk("frz_head_pc", pc, 32'h200);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, rnd_addr(),
                $urandom_range(0, 2) == 0,
                ($urandom_range(0, 1) != 0) ? m_pc : rnd_addr(),
                rnd_addr(), $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter: BTB_ENTRIES, 16, number of direct-mapped BTB entries; power of two, at least 2.
REQ-003 Parameter: IQ_DEPTH, 4, instruction-queue depth; power of two, at least 2.
REQ-004 Port: CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: RST  input  1  reset; asynchronous, active-high.
REQ-006 Port: ihit  input  1  instruction memory returns imemload for imemaddr this cycle.
REQ-007 Port: imemload  input  32  fetched instruction word.
REQ-008 Port: imemREN  output  1  instruction-memory read request.
REQ-009 Port: imemaddr  output  32  fetch address; always equal to the current PC.
REQ-010 Port: freeze  input  1  stall fetch and dequeue.
REQ-011 Port: misprediction  input  1  redirect to correct_pc and flush.
REQ-012 Port: correct_pc  input  32  redirect target.
REQ-013 Port: update_btb  input  1  resolved-branch update strobe.
REQ-014 Port: update_pc  input  32  PC of the resolved branch.
REQ-015 Port: branch_target  input  32  resolved target.
REQ-016 Port: branch_outcome  input  1  1 = taken.
REQ-017 Port: instr_valid  output  1  queue head is valid.
REQ-018 Port: instr_ready  input  1  consumer accepts the head.
REQ-019 Port: instr  output  32  head instruction.
REQ-020 Port: pc  output  32  head PC.
REQ-021 Port: pred_taken  output  1  head was predicted taken.

Function
REQ-022 BTB index is pc[IDX+1:2] and tag is pc[31:IDX+2], where IDX = log2(BTB_ENTRIES); each entry holds valid, tag, a 32-bit target and a 2-bit counter.
REQ-023 Lookup is combinational on the current PC: hit = valid & tag match & counter[1]; next PC = target on hit, else PC+4 (modulo 2^32).
REQ-024 imemREN shall be 1 when the queue count is below IQ_DEPTH, freeze = 0 and misprediction = 0, and 0 otherwise.
REQ-025 When imemREN & ihit: push {imemload, PC, hit} into the queue and load the predicted next PC into the PC register; with one request per cycle, the push is visible at the head one cycle later.
REQ-026 Pop occurs when instr_valid & instr_ready & !freeze; instr, pc and pred_taken are driven combinationally from the head entry.
REQ-027 A simultaneous push and pop shall leave the count unchanged; a full queue shall not push (imemREN = 0), and a pop when full has no same-cycle effect on imemREN.
REQ-028 misprediction has top priority: PC <= correct_pc, the queue is emptied (count 0, pointers reset), and any ihit that cycle is discarded.
REQ-029 freeze (without misprediction) shall hold the PC, the queue contents and the pointers, and force instr_valid = 0.
REQ-030 On update_btb for a miss or invalid entry, the entry shall be allocated with the new tag and target, valid = 1, counter = 2'b10 if taken else 2'b01.
REQ-031 On update_btb for a tag match, the counter shall saturate up on taken and down on not-taken, and the target shall be rewritten on taken.
REQ-032 A BTB write and a lookup to the same index in one cycle: the lookup uses the pre-write contents.
REQ-033 update_btb shall be processed regardless of freeze or misprediction.

Reset
REQ-034 While RST is high: PC = RESET_PC; queue empty; all BTB valid bits = 0 and counters = 2'b00; instr_valid = 0; instr, pc and pred_taken = 0.
REQ-035 When RST is asserted mid-operation it shall take effect immediately, independent of CLK; in-flight fetches are discarded.

Structure
REQ-036 A shared package shall hold the word_t type, the BTB entry struct, the queue entry struct and the counter encodings (STRONG_NT/WEAK_NT/WEAK_T/STRONG_T).
REQ-037 The instruction queue shall be a sub-module, fetch_queue, parametrised by IQ_DEPTH and payload width.

Verification
REQ-038 Reset, then ihit = 1, instr_ready = 1 and imemload = 32'h00000080 for 4 cycles -> heads show pc 0, 4, 8, 12 in order; PC register = 32'h10.
REQ-039 Hold instr_ready = 0 with IQ_DEPTH = 4 -> after 4 pushes imemREN = 0 and the PC is held; one pop -> imemREN = 1 the next cycle.
REQ-040 update_btb with update_pc = 32'h80000000, branch_target = 32'h80000100, taken, then redirect to 32'h80000000 -> head pred_taken = 1 and the next fetch address = 32'h80000100.
REQ-041 Two not-taken updates to the same entry -> counter 2'b10 -> 2'b01 -> 2'b00; a fetch of 32'h80000000 is followed by 32'h80000004.
REQ-042 misprediction with correct_pc = 32'h00000200 while the queue holds 3 entries and ihit = 1 -> the next cycle has instr_valid = 0 and imemaddr = 32'h200; the discarded word never appears.
REQ-043 freeze for 3 cycles with a non-empty queue -> instr_valid = 0 and the PC and count are unchanged; after release the same head is presented.
